// File: rtl/sdram_pkg.sv
// Shared SDRAM pin-bus definitions: command codes, mask values, address bit
// positions and the one-hot engine state encodings used by the read and write engines.
package sdram_pkg;

  // {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CMD_NOP    = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE = 4'b0011;
  localparam logic [3:0] CMD_READ   = 4'b0101;
  localparam logic [3:0] CMD_WRITE  = 4'b0100;

  localparam logic [1:0] DQM_ALL_MASKED  = 2'b11;
  localparam logic [1:0] DQM_NONE_MASKED = 2'b00;

  localparam int unsigned A10_AUTO_PRECHARGE = 10;

  localparam logic [5:0] ST_IDLE     = 6'b00_0001;
  localparam logic [5:0] ST_ACT      = 6'b00_0010;
  localparam logic [5:0] ST_RCD_WAIT = 6'b00_0100;
  localparam logic [5:0] ST_XFER     = 6'b00_1000;
  localparam logic [5:0] ST_RECOVER  = 6'b01_0000;
  localparam logic [5:0] ST_DONE     = 6'b10_0000;

  // Column address with the auto-precharge bit set, upper row bits zero.
  function automatic logic [12:0] col_addr_ap(input logic [9:0] col);
    logic [12:0] a;
    a = 13'd0;
    a[9:0] = col;
    a[A10_AUTO_PRECHARGE] = 1'b1;
    return a;
  endfunction

endpackage

// File: rtl/sdram_nop_timer.sv
// 4-bit NOP-cycle counter with synchronous clear; odone flags count == iterm.
// Shared by the SDRAM read and write engines.
module sdram_nop_timer (
  input  logic       iclk,
  input  logic       ireset_n,
  input  logic       iclr,
  input  logic [3:0] iterm,
  output logic       odone
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    if (iclr) begin
      count_d = 4'd0;
    end else begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign odone = (count_q == iterm);

endmodule

// File: rtl/sdram_write.sv
// Single-word SDRAM write engine: ACTIVE, tRCD, WRITE with auto-precharge, tWR+tRP, done.
// Optional build macro SDRAM_WRITE_BYTE_MASK_EN adds per-byte write enables (ibyte_en).
module sdram_write
  import sdram_pkg::*;
#(
  parameter int unsigned T_RCD   = 3,
  parameter int unsigned T_WR_RP = 4
) (
  input  logic        iclk,
  input  logic        ireset_n,
  input  logic        ireq,
  input  logic        ienb,
  output logic        ofin,
  input  logic [12:0] irow,
  input  logic [9:0]  icolumn,
  input  logic [1:0]  ibank,
  input  logic [15:0] idata,
`ifdef SDRAM_WRITE_BYTE_MASK_EN
  input  logic [1:0]  ibyte_en,
`endif
  output wire         DRAM_CLK,
  output wire         DRAM_CKE,
  output wire  [12:0] DRAM_ADDR,
  output wire  [1:0]  DRAM_BA,
  output wire         DRAM_CS_N,
  output wire         DRAM_RAS_N,
  output wire         DRAM_CAS_N,
  output wire         DRAM_WE_N,
  output wire         DRAM_LDQM,
  output wire         DRAM_UDQM,
  inout  wire  [15:0] DRAM_DQ
);

  localparam logic [3:0] RCD_TERM   = 4'(T_RCD - 1);
  localparam logic [3:0] WR_RP_TERM = 4'(T_WR_RP - 1);

  logic [5:0]  state_q, state_d;
  logic [12:0] row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic [1:0]  bank_q, bank_d;
  logic [15:0] data_q, data_d;
  logic        load_s;

  logic [3:0]  cmd_q, cmd_d;
  logic [12:0] addr_q, addr_d;
  logic [1:0]  ba_q, ba_d;
  logic [1:0]  dqm_q, dqm_d;
  logic        dq_oe_q, dq_oe_d;
  logic [15:0] dq_q, dq_d;
  logic        ofin_q, ofin_d;

  logic        tmr_clr_s;
  logic        tmr_done_s;
  logic [3:0]  tmr_term_s;
  logic [1:0]  wr_dqm_s;

  assign tmr_clr_s  = !((state_q == ST_RCD_WAIT) || (state_q == ST_RECOVER));
  assign tmr_term_s = (state_q == ST_RCD_WAIT) ? RCD_TERM : WR_RP_TERM;

  sdram_nop_timer u_timer (
    .iclk     (iclk),
    .ireset_n (ireset_n),
    .iclr     (tmr_clr_s),
    .iterm    (tmr_term_s),
    .odone    (tmr_done_s)
  );

  // DONE also samples ireq so a held request restarts without an IDLE gap.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ireq) begin
          state_d = ST_ACT;
          load_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACT:      state_d = ST_RCD_WAIT;
      ST_RCD_WAIT: begin
        if (tmr_done_s) begin
          state_d = ST_XFER;
        end else begin
          state_d = ST_RCD_WAIT;
        end
      end
      ST_XFER:     state_d = ST_RECOVER;
      ST_RECOVER: begin
        if (tmr_done_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RECOVER;
        end
      end
      ST_DONE: begin
        if (ireq) begin
          state_d = ST_ACT;
          load_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if (load_s) begin
      row_d  = irow;
      col_d  = icolumn;
      bank_d = ibank;
      data_d = idata;
    end else begin
      row_d  = row_q;
      col_d  = col_q;
      bank_d = bank_q;
      data_d = data_q;
    end
  end

`ifdef SDRAM_WRITE_BYTE_MASK_EN
  logic [1:0] be_q, be_d;

  always_comb begin
    if (load_s) begin
      be_d = ibyte_en;
    end else begin
      be_d = be_q;
    end
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      be_q <= 2'b00;
    end else begin
      be_q <= be_d;
    end
  end

  assign wr_dqm_s = ~be_d;
`else
  assign wr_dqm_s = DQM_NONE_MASKED;
`endif

  // Pin values follow the next state so they change on the same edge as the FSM.
  always_comb begin
    cmd_d   = CMD_NOP;
    addr_d  = addr_q;
    ba_d    = ba_q;
    dqm_d   = DQM_ALL_MASKED;
    dq_oe_d = 1'b0;
    dq_d    = dq_q;
    ofin_d  = 1'b0;
    case (state_d)
      ST_ACT: begin
        cmd_d  = CMD_ACTIVE;
        addr_d = row_d;
        ba_d   = bank_d;
      end
      ST_XFER: begin
        cmd_d   = CMD_WRITE;
        addr_d  = col_addr_ap(col_d);
        ba_d    = bank_d;
        dqm_d   = wr_dqm_s;
        dq_oe_d = 1'b1;
        dq_d    = data_d;
      end
      ST_DONE: ofin_d = 1'b1;
      default: ofin_d = 1'b0;
    endcase
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q <= ST_IDLE;
      row_q   <= 13'd0;
      col_q   <= 10'd0;
      bank_q  <= 2'd0;
      data_q  <= 16'd0;
      cmd_q   <= CMD_NOP;
      addr_q  <= 13'd0;
      ba_q    <= 2'd0;
      dqm_q   <= DQM_ALL_MASKED;
      dq_oe_q <= 1'b0;
      dq_q    <= 16'd0;
      ofin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bank_q  <= bank_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      dqm_q   <= dqm_d;
      dq_oe_q <= dq_oe_d;
      dq_q    <= dq_d;
      ofin_q  <= ofin_d;
    end
  end

  assign ofin = ofin_q;

  // Bus is shared with the read engine: float everything unless we own it.
  assign DRAM_CLK   = ienb ? iclk     : 1'bz;
  assign DRAM_CKE   = ienb ? 1'b1     : 1'bz;
  assign DRAM_ADDR  = ienb ? addr_q   : 13'bz;
  assign DRAM_BA    = ienb ? ba_q     : 2'bz;
  assign DRAM_CS_N  = ienb ? cmd_q[3] : 1'bz;
  assign DRAM_RAS_N = ienb ? cmd_q[2] : 1'bz;
  assign DRAM_CAS_N = ienb ? cmd_q[1] : 1'bz;
  assign DRAM_WE_N  = ienb ? cmd_q[0] : 1'bz;
  assign DRAM_UDQM  = ienb ? dqm_q[1] : 1'bz;
  assign DRAM_LDQM  = ienb ? dqm_q[0] : 1'bz;
  assign DRAM_DQ    = (ienb && dq_oe_q) ? dq_q : 16'bz;

endmodule

// File: tb/tb_sdram_write.sv
// Self-checking bench for sdram_write: scoreboard of expected pin events per cycle.
// High-Z is detected by running twin DUTs on pulled-up and pulled-down nets.
module tb_sdram_write;
  import sdram_pkg::*;

  localparam int unsigned T_RCD   = 3;
  localparam int unsigned T_WR_RP = 4;
  localparam int unsigned TXN     = T_RCD + T_WR_RP + 3;

  logic        iclk;
  logic        ireset_n;
  logic        ireq;
  logic        ireq_f;
  logic        ienb;
  logic [12:0] irow;
  logic [9:0]  icolumn;
  logic [1:0]  ibank;
  logic [15:0] idata;
`ifdef SDRAM_WRITE_BYTE_MASK_EN
  logic [1:0]  ibyte_en;
  localparam logic [1:0] WR_DQM = 2'b01;
`else
  localparam logic [1:0] WR_DQM = 2'b00;
`endif

  tri1 clk_u, cke_u, cs_u, ras_u, cas_u, we_u, ldqm_u, udqm_u;
  tri1 [12:0] addr_u;
  tri1 [1:0]  ba_u;
  tri1 [15:0] dq_u;
  wire ofin_u;
  tri0 clk_d, cke_d, cs_d, ras_d, cas_d, we_d, ldqm_d, udqm_d;
  tri0 [12:0] addr_d;
  tri0 [1:0]  ba_d;
  tri0 [15:0] dq_d;
  wire ofin_d;
  tri1 clk_f, cke_f, cs_f, ras_f, cas_f, we_f, ldqm_f, udqm_f;
  tri1 [12:0] addr_f;
  tri1 [1:0]  ba_f;
  tri1 [15:0] dq_f;
  wire ofin_f;

  sdram_write #(.T_RCD(T_RCD), .T_WR_RP(T_WR_RP)) u_dut (
    .iclk(iclk), .ireset_n(ireset_n), .ireq(ireq), .ienb(ienb), .ofin(ofin_u),
    .irow(irow), .icolumn(icolumn), .ibank(ibank), .idata(idata),
`ifdef SDRAM_WRITE_BYTE_MASK_EN
    .ibyte_en(ibyte_en),
`endif
    .DRAM_CLK(clk_u), .DRAM_CKE(cke_u), .DRAM_ADDR(addr_u), .DRAM_BA(ba_u),
    .DRAM_CS_N(cs_u), .DRAM_RAS_N(ras_u), .DRAM_CAS_N(cas_u), .DRAM_WE_N(we_u),
    .DRAM_LDQM(ldqm_u), .DRAM_UDQM(udqm_u), .DRAM_DQ(dq_u)
  );

  sdram_write #(.T_RCD(T_RCD), .T_WR_RP(T_WR_RP)) u_dut_pd (
    .iclk(iclk), .ireset_n(ireset_n), .ireq(ireq), .ienb(ienb), .ofin(ofin_d),
    .irow(irow), .icolumn(icolumn), .ibank(ibank), .idata(idata),
`ifdef SDRAM_WRITE_BYTE_MASK_EN
    .ibyte_en(ibyte_en),
`endif
    .DRAM_CLK(clk_d), .DRAM_CKE(cke_d), .DRAM_ADDR(addr_d), .DRAM_BA(ba_d),
    .DRAM_CS_N(cs_d), .DRAM_RAS_N(ras_d), .DRAM_CAS_N(cas_d), .DRAM_WE_N(we_d),
    .DRAM_LDQM(ldqm_d), .DRAM_UDQM(udqm_d), .DRAM_DQ(dq_d)
  );

  sdram_write #(.T_RCD(1), .T_WR_RP(1)) u_dut_fast (
    .iclk(iclk), .ireset_n(ireset_n), .ireq(ireq_f), .ienb(ienb), .ofin(ofin_f),
    .irow(irow), .icolumn(icolumn), .ibank(ibank), .idata(idata),
`ifdef SDRAM_WRITE_BYTE_MASK_EN
    .ibyte_en(ibyte_en),
`endif
    .DRAM_CLK(clk_f), .DRAM_CKE(cke_f), .DRAM_ADDR(addr_f), .DRAM_BA(ba_f),
    .DRAM_CS_N(cs_f), .DRAM_RAS_N(ras_f), .DRAM_CAS_N(cas_f), .DRAM_WE_N(we_f),
    .DRAM_LDQM(ldqm_f), .DRAM_UDQM(udqm_f), .DRAM_DQ(dq_f)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic [1:0]  dqm;
    logic        dq_en;
    logic [15:0] dq;
    logic        fin;
  } exp_t;

  exp_t q[$];
  exp_t qf[$];
  int   cyc;
  int   n_checks;
  int   n_errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic push_txn(input bit fast, input int base, input int trcd, input int twr,
                          input logic [12:0] row, input logic [9:0] col,
                          input logic [1:0] bank, input logic [15:0] data);
    exp_t e;
    e = '{cyc: base + 1, cmd: CMD_ACTIVE, addr: row, ba: bank, dqm: 2'b11,
          dq_en: 1'b0, dq: 16'd0, fin: 1'b0};
    if (fast) qf.push_back(e); else q.push_back(e);
    e = '{cyc: base + trcd + 2, cmd: CMD_WRITE, addr: {3'b001, col}, ba: bank, dqm: WR_DQM,
          dq_en: 1'b1, dq: data, fin: 1'b0};
    if (fast) qf.push_back(e); else q.push_back(e);
    e = '{cyc: base + trcd + twr + 3, cmd: CMD_NOP, addr: 13'd0, ba: 2'd0, dqm: 2'b11,
          dq_en: 1'b0, dq: 16'd0, fin: 1'b1};
    if (fast) qf.push_back(e); else q.push_back(e);
  endtask

  task automatic check_main();
    exp_t e;
    bit   has;
    e = '{cyc: cyc, cmd: CMD_NOP, addr: 13'd0, ba: 2'd0, dqm: 2'b11,
          dq_en: 1'b0, dq: 16'd0, fin: 1'b0};
    has = 1'b0;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      has = 1'b1;
    end
    chk("ofin", 32'(ofin_u), 32'(e.fin));
    chk("ofin_pd", 32'(ofin_d), 32'(e.fin));
    if (ienb) begin
      chk("dram_clk", 32'(clk_u), 32'd1);
      chk("dram_cke", 32'(cke_u), 32'd1);
      chk("cmd", 32'({cs_u, ras_u, cas_u, we_u}), 32'(e.cmd));
      chk("dqm", 32'({udqm_u, ldqm_u}), 32'(e.dqm));
      if (has && e.cmd != CMD_NOP) begin
        chk("addr", 32'(addr_u), 32'(e.addr));
        chk("ba", 32'(ba_u), 32'(e.ba));
      end
      if (e.dq_en) begin
        chk("dq", 32'(dq_u), 32'(e.dq));
        chk("dq_pd", 32'(dq_d), 32'(e.dq));
      end else begin
        chk("dq_released", {dq_u, dq_d}, {16'hFFFF, 16'h0000});
      end
    end else begin
      chk("float_up", 32'({clk_u, cke_u, cs_u, ras_u, cas_u, we_u, udqm_u, ldqm_u, ba_u, addr_u}),
          32'h007F_FFFF);
      chk("float_dn", 32'({clk_d, cke_d, cs_d, ras_d, cas_d, we_d, udqm_d, ldqm_d, ba_d, addr_d}),
          32'h0000_0000);
      chk("float_dq", {dq_u, dq_d}, {16'hFFFF, 16'h0000});
    end
  endtask

  task automatic check_fast();
    exp_t e;
    e = '{cyc: cyc, cmd: CMD_NOP, addr: 13'd0, ba: 2'd0, dqm: 2'b11,
          dq_en: 1'b0, dq: 16'd0, fin: 1'b0};
    if (qf.size() > 0 && qf[0].cyc == cyc) begin
      e = qf.pop_front();
    end
    chk("fast_ofin", 32'(ofin_f), 32'(e.fin));
    if (ienb) begin
      chk("fast_cmd", 32'({cs_f, ras_f, cas_f, we_f}), 32'(e.cmd));
      if (e.dq_en) begin
        chk("fast_dq", 32'(dq_f), 32'(e.dq));
      end
    end
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
    cyc++;
    check_main();
    check_fast();
  endtask

  initial begin
    int base;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    ireset_n = 1'b0;
    ireq     = 1'b0;
    ireq_f   = 1'b0;
    ienb     = 1'b1;
    irow     = 13'd0;
    icolumn  = 10'd0;
    ibank    = 2'd0;
    idata    = 16'd0;
`ifdef SDRAM_WRITE_BYTE_MASK_EN
    ibyte_en = 2'b10;
`endif
    // reset state
    step();
    step();
    chk("rst_addr", 32'(addr_u), 32'd0);
    chk("rst_ba", 32'(ba_u), 32'd0);
    ireset_n = 1'b1;
    step();
    step();

    // basic transaction; inputs change after capture and a mid-flight ireq is ignored
    irow = 13'h1A5; icolumn = 10'h02F; ibank = 2'd2; idata = 16'hBEEF;
    ireq = 1'b1;
    push_txn(1'b0, cyc, T_RCD, T_WR_RP, 13'h1A5, 10'h02F, 2'd2, 16'hBEEF);
    step();
    ireq = 1'b0;
    irow = 13'h0F0F; icolumn = 10'h155; ibank = 2'd1; idata = 16'h1234;
    step();
    step();
    ireq = 1'b1;
    step();
    ireq = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // bus not owned: pins float, ofin still pulses
    ienb = 1'b0;
    irow = 13'h0ABC; icolumn = 10'h3FF; ibank = 2'd1; idata = 16'h5A5A;
    ireq = 1'b1;
    push_txn(1'b0, cyc, T_RCD, T_WR_RP, 13'h0ABC, 10'h3FF, 2'd1, 16'h5A5A);
    step();
    ireq = 1'b0;
    for (int i = 0; i < 11; i++) step();
    ienb = 1'b1;
    step();

    // ireq held high for 25 cycles: back-to-back transactions from DONE
    irow = 13'h1FFF; icolumn = 10'h000; ibank = 2'd3; idata = 16'h8001;
    ireq = 1'b1;
    base = cyc;
    push_txn(1'b0, base, T_RCD, T_WR_RP, 13'h1FFF, 10'h000, 2'd3, 16'h8001);
    push_txn(1'b0, base + TXN, T_RCD, T_WR_RP, 13'h1FFF, 10'h000, 2'd3, 16'h8001);
    push_txn(1'b0, base + 2 * TXN, T_RCD, T_WR_RP, 13'h1FFF, 10'h000, 2'd3, 16'h8001);
    for (int i = 0; i < 25; i++) step();
    ireq = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("queue_drained", 32'(q.size()), 32'd0);

    // reset asserted in the middle of the WRITE cycle
    irow = 13'h0123; icolumn = 10'h2AA; ibank = 2'd0; idata = 16'hC3C3;
    ireq = 1'b1;
    base = cyc;
    push_txn(1'b0, base, T_RCD, T_WR_RP, 13'h0123, 10'h2AA, 2'd0, 16'hC3C3);
    step();
    ireq = 1'b0;
    while (cyc < base + int'(T_RCD) + 2) step();
    #2;
    ireset_n = 1'b0;
    #1;
    chk("rst_wr_cmd", 32'({cs_u, ras_u, cas_u, we_u}), 32'(CMD_NOP));
    chk("rst_wr_dqm", 32'({udqm_u, ldqm_u}), 32'd3);
    chk("rst_wr_dq", {dq_u, dq_d}, {16'hFFFF, 16'h0000});
    q.delete();
    qf.delete();
    step();
    ireset_n = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // short timing instance: WRITE in cycle 3, ofin in cycle 5
    irow = 13'h0777; icolumn = 10'h011; ibank = 2'd1; idata = 16'h0F0F;
    ireq_f = 1'b1;
    push_txn(1'b1, cyc, 1, 1, 13'h0777, 10'h011, 2'd1, 16'h0F0F);
    step();
    ireq_f = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("fast_queue_drained", 32'(qf.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
